// File: rtl/axi_mm_pat_pkg.sv
// ---------------------------------------------------------------------------
// axi_mm_pat_pkg
// Shared types and constants for the AXI-MM pattern generator/checker pair.
//   chkr_state_e      : checker FSM states
//   AXI_LANE_W        : width of one AXI data lane (bits)
//   CHKR_AFULL_MARGIN : free entries kept when raising chkr_fifo_full
// ---------------------------------------------------------------------------
package axi_mm_pat_pkg;

   typedef enum logic [1:0] {
      CHKR_IDLE = 2'd0,
      CHKR_RUN  = 2'd1,
      CHKR_DONE = 2'd2
   } chkr_state_e;

   localparam int AXI_LANE_W        = 64;
   localparam int CHKR_AFULL_MARGIN = 2;

endpackage : axi_mm_pat_pkg

// File: rtl/axi_mm_chkr_fifo.sv
// ---------------------------------------------------------------------------
// axi_mm_chkr_fifo
// Synchronous FIFO holding expected-data words for the pattern checker.
// A write while full is dropped unless a read happens in the same cycle.
// Reads and writes in the same cycle never bypass: an empty FIFO cannot
// serve a read with the word being written in that cycle.
//
// Ports:
//   wr_clk   in  clock
//   rst_n    in  synchronous active-low reset (pointers and count only)
//   flush    in  synchronous empty request
//   wr_en    in  write request
//   din      in  DATA_W write data
//   rd_en    in  read (pop) request
//   dout     out DATA_W head-of-FIFO word
//   count    out occupancy, 0..DEPTH
//   empty    out occupancy == 0
//   wr_drop  out write request rejected this cycle
// ---------------------------------------------------------------------------
module axi_mm_chkr_fifo #(
   parameter int DATA_W = 64,
   parameter int DEPTH  = 16
) (
   input  logic                       wr_clk,
   input  logic                       rst_n,
   input  logic                       flush,
   input  logic                       wr_en,
   input  logic [DATA_W-1:0]          din,
   input  logic                       rd_en,
   output logic [DATA_W-1:0]          dout,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       empty,
   output logic                       wr_drop
);

   localparam int AW = $clog2(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic [AW:0]       cnt;
   logic              full;
   logic              rd_ok;
   logic              wr_ok;

   assign empty   = (cnt == '0);
   assign full    = (cnt == (AW+1)'(DEPTH));
   assign rd_ok   = rd_en && !empty;
   // A pop in the same cycle frees the slot, so a full FIFO still accepts.
   assign wr_ok   = wr_en && (!full || rd_ok);
   assign wr_drop = wr_en && !wr_ok;
   assign dout    = mem[rd_ptr];
   assign count   = cnt;

   always_ff @(posedge wr_clk) begin
      if (!rst_n || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
         if (rd_ok) rd_ptr <= rd_ptr + AW'(1);
         case ({wr_ok, rd_ok})
            2'b10:   cnt <= cnt + (AW+1)'(1);
            2'b01:   cnt <= cnt - (AW+1)'(1);
            default: cnt <= cnt;
         endcase
      end
   end

   // Storage is data only; it needs no reset.
   always_ff @(posedge wr_clk) begin
      if (wr_ok) mem[wr_ptr] <= din;
   end

endmodule : axi_mm_chkr_fifo

// File: rtl/axi_mm_patchkr.sv
// ---------------------------------------------------------------------------
// axi_mm_patchkr
// Pattern checker downstream of the AXI-MM pattern generator. Expected words
// from the generator are buffered in a FIFO and compared in order against
// received beats. Reports pass/fail, error and beat counts, and throttles the
// generator through chkr_fifo_full.
//
// Optional build macro: AXI_MM_PATCHKR_FIRST_ERR_EN
//   defined   : first_err_* capture the first error event of each run
//   undefined : first_err_* are tied to 0
//
// Ports:
//   wr_clk          in  clock
//   rst_n           in  synchronous active-low reset
//   chkr_en         in  rising edge starts a run; low returns to idle
//   cntuspatt_en    in  continuous mode (run never completes on count)
//   patgen_cnt      in  8-bit beat count of a finite run
//   exp_wr          in  expected-word push
//   exp_din         in  W expected word
//   chkr_fifo_full  out almost-full back-pressure to the generator
//   rx_valid        in  received beat valid
//   rx_data         in  W received beat
//   chkr_busy       out high while running
//   chkr_pass       out run completed with no errors and nothing left over
//   chkr_fail       out sticky error flag for the current run
//   err_cnt         out ERR_CNT_W mismatch + underflow + overflow events
//   rx_cnt          out ERR_CNT_W received beats in the current run
//   first_err_idx   out ERR_CNT_W beat index of the first error
//   first_err_rx    out W received data of the first error
//   first_err_exp   out W expected data of the first error
// ---------------------------------------------------------------------------
module axi_mm_patchkr
   import axi_mm_pat_pkg::*;
#(
   parameter int AXI_CHNL_NUM = 1,
   parameter int EXP_DEPTH    = 16,
   parameter int ERR_CNT_W    = 16
) (
   input  logic                                 wr_clk,
   input  logic                                 rst_n,
   input  logic                                 chkr_en,
   input  logic                                 cntuspatt_en,
   input  logic [7:0]                           patgen_cnt,
   input  logic                                 exp_wr,
   input  logic [AXI_CHNL_NUM*AXI_LANE_W-1:0]   exp_din,
   output logic                                 chkr_fifo_full,
   input  logic                                 rx_valid,
   input  logic [AXI_CHNL_NUM*AXI_LANE_W-1:0]   rx_data,
   output logic                                 chkr_busy,
   output logic                                 chkr_pass,
   output logic                                 chkr_fail,
   output logic [ERR_CNT_W-1:0]                 err_cnt,
   output logic [ERR_CNT_W-1:0]                 rx_cnt,
   output logic [ERR_CNT_W-1:0]                 first_err_idx,
   output logic [AXI_CHNL_NUM*AXI_LANE_W-1:0]   first_err_rx,
   output logic [AXI_CHNL_NUM*AXI_LANE_W-1:0]   first_err_exp
);

   localparam int W  = AXI_CHNL_NUM * AXI_LANE_W;
   localparam int CW = $clog2(EXP_DEPTH) + 1;

   // Saturating add for the event counters; counts stick at all-ones.
   function automatic logic [ERR_CNT_W-1:0] sat_add(
      input logic [ERR_CNT_W-1:0] a,
      input logic [1:0]           b
   );
      logic [ERR_CNT_W:0] s;
      s = {1'b0, a} + {{(ERR_CNT_W-1){1'b0}}, b};
      return s[ERR_CNT_W] ? {ERR_CNT_W{1'b1}} : s[ERR_CNT_W-1:0];
   endfunction

   chkr_state_e          state;
   chkr_state_e          state_nxt;
   logic                 chkr_en_d;
   logic                 en_rise;
   logic                 run;
   logic                 flush;

   logic                 push;
   logic                 pop_req;
   logic [W-1:0]         fifo_dout;
   logic [CW-1:0]        fifo_count;
   logic                 fifo_empty;
   logic                 fifo_wr_drop;

   logic                 underflow;
   logic                 pop_ok;
   logic                 push_ok;
   logic                 mismatch;
   logic                 overflow;
   logic [1:0]           err_inc;
   logic [ERR_CNT_W-1:0] err_cnt_nxt;
   logic [ERR_CNT_W-1:0] rx_cnt_nxt;
   logic [CW-1:0]        occ_nxt;
   logic                 done_hit;

   assign en_rise   = chkr_en && !chkr_en_d;
   assign run       = (state == CHKR_RUN);
   assign flush     = (state == CHKR_IDLE) && en_rise;
   assign chkr_busy = run;

   // Pushes and pops are only honoured while running.
   assign push      = run && exp_wr;
   assign pop_req   = run && rx_valid;

   axi_mm_chkr_fifo #(
      .DATA_W (W),
      .DEPTH  (EXP_DEPTH)
   ) u_fifo (
      .wr_clk  (wr_clk),
      .rst_n   (rst_n),
      .flush   (flush),
      .wr_en   (push),
      .din     (exp_din),
      .rd_en   (pop_req),
      .dout    (fifo_dout),
      .count   (fifo_count),
      .empty   (fifo_empty),
      .wr_drop (fifo_wr_drop)
   );

   assign chkr_fifo_full = (fifo_count >= CW'(EXP_DEPTH - CHKR_AFULL_MARGIN));

   // Stage p0: error classification, all from registered FIFO state.
   assign underflow = pop_req && fifo_empty;
   assign pop_ok    = pop_req && !fifo_empty;
   assign mismatch  = pop_ok && (fifo_dout != rx_data);
   assign overflow  = fifo_wr_drop;
   assign push_ok   = push && !fifo_wr_drop;
   // mismatch and underflow are exclusive, so the sum is at most 2.
   assign err_inc   = {1'b0, mismatch} + {1'b0, underflow} + {1'b0, overflow};

   assign err_cnt_nxt = sat_add(err_cnt, err_inc);
   assign rx_cnt_nxt  = pop_req ? sat_add(rx_cnt, 2'd1) : rx_cnt;
   assign occ_nxt     = fifo_count + CW'(push_ok) - CW'(pop_ok);

   // Completion looks at the registered beat count, so the state change
   // lands one cycle after the final beat has been counted.
   assign done_hit = run && chkr_en && !cntuspatt_en &&
                     (rx_cnt == ERR_CNT_W'(patgen_cnt));

   always_comb begin
      state_nxt = state;
      case (state)
         CHKR_IDLE: if (en_rise) state_nxt = CHKR_RUN;
         CHKR_RUN: begin
            if (!chkr_en)      state_nxt = CHKR_IDLE;
            else if (done_hit) state_nxt = CHKR_DONE;
         end
         CHKR_DONE: if (!chkr_en) state_nxt = CHKR_IDLE;
         default:   state_nxt = CHKR_IDLE;
      endcase
   end

   // Stage p1: state, counters and result flags.
   always_ff @(posedge wr_clk) begin
      if (!rst_n) begin
         state     <= CHKR_IDLE;
         chkr_en_d <= 1'b0;
         rx_cnt    <= '0;
         err_cnt   <= '0;
         chkr_fail <= 1'b0;
         chkr_pass <= 1'b0;
      end else begin
         state     <= state_nxt;
         chkr_en_d <= chkr_en;
         if (flush) begin
            rx_cnt    <= '0;
            err_cnt   <= '0;
            chkr_fail <= 1'b0;
            chkr_pass <= 1'b0;
         end else if (run) begin
            rx_cnt  <= rx_cnt_nxt;
            err_cnt <= err_cnt_nxt;
            if (err_inc != 2'd0) chkr_fail <= 1'b1;
            // Verdict uses post-cycle values so a beat or push in the
            // final RUN cycle is accounted for.
            if (done_hit) begin
               chkr_pass <= (err_cnt_nxt == '0) && (occ_nxt == '0);
               if (occ_nxt != '0) chkr_fail <= 1'b1;
            end
         end
      end
   end

`ifdef AXI_MM_PATCHKR_FIRST_ERR_EN
   logic                 fe_seen;
   logic [ERR_CNT_W-1:0] fe_idx;
   logic [W-1:0]         fe_rx;
   logic [W-1:0]         fe_exp;

   // Receive-side errors take priority over an overflow in the same cycle.
   always_ff @(posedge wr_clk) begin
      if (!rst_n || flush) begin
         fe_seen <= 1'b0;
         fe_idx  <= '0;
         fe_rx   <= '0;
         fe_exp  <= '0;
      end else if (run && (err_inc != 2'd0) && !fe_seen) begin
         fe_seen <= 1'b1;
         fe_idx  <= rx_cnt;
         if (mismatch || underflow) begin
            fe_rx  <= rx_data;
            fe_exp <= mismatch ? fifo_dout : '0;
         end else begin
            fe_rx  <= '0;
            fe_exp <= exp_din;
         end
      end
   end

   assign first_err_idx = fe_idx;
   assign first_err_rx  = fe_rx;
   assign first_err_exp = fe_exp;
`else
   assign first_err_idx = '0;
   assign first_err_rx  = '0;
   assign first_err_exp = '0;
`endif

endmodule : axi_mm_patchkr

// File: tb/tb_axi_mm_patchkr.sv
// ---------------------------------------------------------------------------
// tb_axi_mm_patchkr
// Directed self-checking bench for axi_mm_patchkr (AXI_CHNL_NUM=1,
// EXP_DEPTH=16, ERR_CNT_W=16). A behavioural model predicts every output for
// each driven cycle; predictions are queued on a scoreboard and compared
// after the clock edge.
// ---------------------------------------------------------------------------
module tb_axi_mm_patchkr;

   localparam int W     = 64;
   localparam int DEPTH = 16;
   localparam int CW    = 16;

   logic          wr_clk = 1'b0;
   logic          rst_n;
   logic          chkr_en;
   logic          cntuspatt_en;
   logic [7:0]    patgen_cnt;
   logic          exp_wr;
   logic [W-1:0]  exp_din;
   logic          chkr_fifo_full;
   logic          rx_valid;
   logic [W-1:0]  rx_data;
   logic          chkr_busy;
   logic          chkr_pass;
   logic          chkr_fail;
   logic [CW-1:0] err_cnt;
   logic [CW-1:0] rx_cnt;
   logic [CW-1:0] first_err_idx;
   logic [W-1:0]  first_err_rx;
   logic [W-1:0]  first_err_exp;

   always #5 wr_clk = ~wr_clk;

   axi_mm_patchkr #(
      .AXI_CHNL_NUM (1),
      .EXP_DEPTH    (DEPTH),
      .ERR_CNT_W    (CW)
   ) dut (
      .wr_clk         (wr_clk),
      .rst_n          (rst_n),
      .chkr_en        (chkr_en),
      .cntuspatt_en   (cntuspatt_en),
      .patgen_cnt     (patgen_cnt),
      .exp_wr         (exp_wr),
      .exp_din        (exp_din),
      .chkr_fifo_full (chkr_fifo_full),
      .rx_valid       (rx_valid),
      .rx_data        (rx_data),
      .chkr_busy      (chkr_busy),
      .chkr_pass      (chkr_pass),
      .chkr_fail      (chkr_fail),
      .err_cnt        (err_cnt),
      .rx_cnt         (rx_cnt),
      .first_err_idx  (first_err_idx),
      .first_err_rx   (first_err_rx),
      .first_err_exp  (first_err_exp)
   );

   typedef struct {
      logic [CW-1:0] err;
      logic [CW-1:0] rxc;
      logic          fail;
      logic          pass;
      logic          busy;
      logic          full;
      logic [CW-1:0] fidx;
      logic [W-1:0]  frx;
      logic [W-1:0]  fexp;
   } snap_t;

   snap_t        sb[$];
   logic [W-1:0] m_q[$];

   // Model state: 0 idle, 1 run, 2 done
   int            m_st;
   logic          m_en_d;
   int            m_err;
   int            m_rx;
   logic          m_fail;
   logic          m_pass;
   logic          m_fe_seen;
   logic [CW-1:0] m_fe_idx;
   logic [W-1:0]  m_fe_rx;
   logic [W-1:0]  m_fe_exp;

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic snap_t model_snap();
      snap_t s;
      s.err  = CW'(m_err);
      s.rxc  = CW'(m_rx);
      s.fail = m_fail;
      s.pass = m_pass;
      s.busy = (m_st == 1);
      s.full = (m_q.size() >= DEPTH - 2);
`ifdef AXI_MM_PATCHKR_FIRST_ERR_EN
      s.fidx = m_fe_idx;
      s.frx  = m_fe_rx;
      s.fexp = m_fe_exp;
`else
      s.fidx = '0;
      s.frx  = '0;
      s.fexp = '0;
`endif
      return s;
   endfunction

   function automatic int sat(input int v);
      return (v > 65535) ? 65535 : v;
   endfunction

   task automatic model_reset();
      m_q.delete();
      m_st = 0; m_en_d = 1'b0; m_err = 0; m_rx = 0;
      m_fail = 1'b0; m_pass = 1'b0;
      m_fe_seen = 1'b0; m_fe_idx = '0; m_fe_rx = '0; m_fe_exp = '0;
   endtask

   task automatic model_cycle(input logic push, input logic [W-1:0] pd,
                              input logic rx, input logic [W-1:0] rd);
      logic         rise;
      logic         pop_ok, unf, ovf, mis;
      int           size0, old_rx, inc;
      logic [W-1:0] e;
      rise   = chkr_en && !m_en_d;
      m_en_d = chkr_en;
      case (m_st)
         0: if (rise) begin
            m_q.delete();
            m_err = 0; m_rx = 0; m_fail = 1'b0; m_pass = 1'b0;
            m_fe_seen = 1'b0; m_fe_idx = '0; m_fe_rx = '0; m_fe_exp = '0;
            m_st = 1;
         end
         1: begin
            old_rx = m_rx;
            size0  = m_q.size();
            pop_ok = rx && (size0 != 0);
            unf    = rx && (size0 == 0);
            mis    = 1'b0;
            e      = '0;
            if (pop_ok) begin
               e   = m_q.pop_front();
               mis = (e !== rd);
            end
            ovf = push && (size0 == DEPTH) && !pop_ok;
            if (push && !ovf) m_q.push_back(pd);
            inc   = int'(mis) + int'(unf) + int'(ovf);
            m_err = sat(m_err + inc);
            if (rx) m_rx = sat(m_rx + 1);
            if (inc != 0) m_fail = 1'b1;
            if (inc != 0 && !m_fe_seen) begin
               m_fe_seen = 1'b1;
               m_fe_idx  = CW'(old_rx);
               if (mis || unf) begin
                  m_fe_rx  = rd;
                  m_fe_exp = mis ? e : '0;
               end else begin
                  m_fe_rx  = '0;
                  m_fe_exp = pd;
               end
            end
            if (!chkr_en) m_st = 0;
            else if (!cntuspatt_en && old_rx == int'(patgen_cnt)) begin
               m_st   = 2;
               m_pass = (m_err == 0) && (m_q.size() == 0);
               if (m_q.size() != 0) m_fail = 1'b1;
            end
         end
         default: if (!chkr_en) m_st = 0;
      endcase
   endtask

   task automatic compare_head(input string tag);
      snap_t s;
      s = sb.pop_front();
      chk({tag, ".err_cnt"},   64'(err_cnt),        64'(s.err));
      chk({tag, ".rx_cnt"},    64'(rx_cnt),         64'(s.rxc));
      chk({tag, ".fail"},      64'(chkr_fail),      64'(s.fail));
      chk({tag, ".pass"},      64'(chkr_pass),      64'(s.pass));
      chk({tag, ".busy"},      64'(chkr_busy),      64'(s.busy));
      chk({tag, ".full"},      64'(chkr_fifo_full), 64'(s.full));
      chk({tag, ".fe_idx"},    64'(first_err_idx),  64'(s.fidx));
      chk({tag, ".fe_rx"},     first_err_rx,        s.frx);
      chk({tag, ".fe_exp"},    first_err_exp,       s.fexp);
   endtask

   task automatic step(input string tag, input logic push, input logic [W-1:0] pd,
                       input logic rx, input logic [W-1:0] rd);
      @(negedge wr_clk);
      exp_wr = push; exp_din = pd; rx_valid = rx; rx_data = rd;
      model_cycle(push, pd, rx, rd);
      sb.push_back(model_snap());
      @(posedge wr_clk);
      #1;
      compare_head(tag);
   endtask

   task automatic idle(input string tag);
      step(tag, 1'b0, '0, 1'b0, '0);
   endtask

   task automatic reset_step(input string tag);
      @(negedge wr_clk);
      rst_n = 1'b0; chkr_en = 1'b0;
      exp_wr = 1'b0; exp_din = '0; rx_valid = 1'b0; rx_data = '0;
      model_reset();
      sb.push_back(model_snap());
      @(posedge wr_clk);
      #1;
      compare_head(tag);
      rst_n = 1'b1;
   endtask

   task automatic start(input string tag, input logic cont, input logic [7:0] cnt);
      cntuspatt_en = cont;
      patgen_cnt   = cnt;
      chkr_en      = 1'b1;
      idle(tag);
   endtask

   task automatic stop(input string tag);
      chkr_en = 1'b0;
      idle(tag);
   endtask

   function automatic logic [W-1:0] word(input int i);
      return 64'hA5A5_0000_0000_0000 | 64'(i) | (64'(i) << 32);
   endfunction

   initial begin
      logic [W-1:0] bad;
      rst_n = 1'b0; chkr_en = 1'b0; cntuspatt_en = 1'b0; patgen_cnt = '0;
      exp_wr = 1'b0; exp_din = '0; rx_valid = 1'b0; rx_data = '0;
      model_reset();

      reset_step("rst0");
      reset_step("rst1");
      idle("post_rst");

      // Finite pass: 8 words in, same 8 back
      start("pass.start", 1'b0, 8'd8);
      for (int i = 0; i < 8; i++) step("pass.push", 1'b1, word(i), 1'b0, '0);
      for (int i = 0; i < 8; i++) step("pass.rx", 1'b0, '0, 1'b1, word(i));
      idle("pass.done");
      idle("pass.hold");
      stop("pass.stop");

      // Zero-length run completes immediately
      start("zero.start", 1'b0, 8'd0);
      idle("zero.done");
      stop("zero.stop");

      // Single-bit corruption on the 3rd beat
      start("bit.start", 1'b0, 8'd8);
      for (int i = 0; i < 8; i++) step("bit.push", 1'b1, word(100 + i), 1'b0, '0);
      for (int i = 0; i < 8; i++) begin
         bad = word(100 + i);
         if (i == 2) bad[5] = ~bad[5];
         step("bit.rx", 1'b0, '0, 1'b1, bad);
      end
      idle("bit.done");
      stop("bit.stop");

      // Underflow with a same-cycle push, then the pushed word is popped
      start("unf.start", 1'b1, 8'd0);
      step("unf.both", 1'b1, word(200), 1'b1, 64'h1234);
      step("unf.pop", 1'b0, '0, 1'b1, word(200));
      idle("unf.idle");
      stop("unf.stop");

      // Back-pressure and overflow in continuous mode
      start("bp.start", 1'b1, 8'd0);
      for (int i = 0; i < 17; i++) step("bp.push", 1'b1, word(300 + i), 1'b0, '0);
      step("bp.pushpop", 1'b1, word(317), 1'b1, word(300));
      idle("bp.idle");
      stop("bp.stop");

      // Leftover expected word fails the run
      start("left.start", 1'b0, 8'd4);
      for (int i = 0; i < 5; i++) step("left.push", 1'b1, word(400 + i), 1'b0, '0);
      for (int i = 0; i < 4; i++) step("left.rx", 1'b0, '0, 1'b1, word(400 + i));
      idle("left.done");
      stop("left.stop");

      // Reset mid-run with words buffered, then a clean run
      start("mrst.start", 1'b0, 8'd8);
      for (int i = 0; i < 3; i++) step("mrst.push", 1'b1, word(500 + i), 1'b0, '0);
      reset_step("mrst.rst");
      idle("mrst.idle");
      start("mrst.restart", 1'b0, 8'd2);
      for (int i = 0; i < 2; i++) step("mrst.push2", 1'b1, word(600 + i), 1'b0, '0);
      for (int i = 0; i < 2; i++) step("mrst.rx2", 1'b0, '0, 1'b1, word(600 + i));
      idle("mrst.done");
      stop("mrst.stop");

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule : tb_axi_mm_patchkr
